// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : key_debouncer
// Brief    : Per-key synchroniser, stability-counter debouncer, press/release
//            strobes and hold auto-repeat ticks for active-low board keys.
//            The release strobe port is named release_stb because `release`
//            is a reserved word in SystemVerilog.
// Revision : 1.0
// ============================================================================
module key_debouncer #(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_stb,
    output logic [N_KEYS-1:0] hold_tick
);

    localparam int               c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    // Two-flop synchroniser; idles at 1 so a reset looks like "released".
    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_pressed;
        logic               r_press;
        logic               r_release;
        logic               w_raw;
        logic               w_accept;

        assign w_raw    = ~r_sync2[i];
        assign w_accept = (w_raw != r_pressed) && (r_cnt == c_CNT_LAST);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt     <= '0;
                r_pressed <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (w_raw == r_pressed) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt     <= '0;
                    r_pressed <= w_raw;
                    r_press   <= w_raw;
                    r_release <= ~w_raw;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign pressed[i]     = r_pressed;
        assign press[i]       = r_press;
        assign release_stb[i] = r_release;

        if (REPEAT_DELAY > 0) begin : g_repeat
            localparam int c_RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int c_RCNT_W  = $clog2(c_RMAX + 1);
            localparam int c_RCNT_XW = c_RCNT_W + 1;
            localparam logic [c_RCNT_XW-1:0] c_DELAY  = c_RCNT_XW'(REPEAT_DELAY);
            localparam logic [c_RCNT_XW-1:0] c_PERIOD = c_RCNT_XW'(REPEAT_PERIOD);

            typedef enum logic [0:0] {
                RP_DELAY  = 1'b0,
                RP_PERIOD = 1'b1
            } rep_phase_t;

            rep_phase_t            r_phase;
            rep_phase_t            w_phase_nxt;
            logic [c_RCNT_W-1:0]   r_rcnt;
            logic [c_RCNT_W-1:0]   w_rcnt_nxt;
            logic [c_RCNT_XW-1:0]  w_rcnt_inc;
            logic [c_RCNT_XW-1:0]  w_target;
            logic                  r_tick;
            logic                  w_tick_nxt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_phase <= RP_DELAY;
                    r_rcnt  <= '0;
                    r_tick  <= 1'b0;
                end else begin
                    r_phase <= w_phase_nxt;
                    r_rcnt  <= w_rcnt_nxt;
                    r_tick  <= w_tick_nxt;
                end
            end

            assign w_rcnt_inc = {1'b0, r_rcnt} + 1'b1;
            assign w_target   = (r_phase == RP_DELAY) ? c_DELAY : c_PERIOD;

            // Counter restarts at every tick; the phase selects delay vs period.
            always_comb begin
                w_phase_nxt = r_phase;
                w_rcnt_nxt  = r_rcnt;
                w_tick_nxt  = 1'b0;
                if (!r_pressed || w_accept) begin
                    w_phase_nxt = RP_DELAY;
                    w_rcnt_nxt  = '0;
                end else if (w_rcnt_inc == w_target) begin
                    w_phase_nxt = RP_PERIOD;
                    w_rcnt_nxt  = '0;
                    w_tick_nxt  = 1'b1;
                end else begin
                    w_rcnt_nxt  = w_rcnt_inc[c_RCNT_W-1:0];
                end
            end

            assign hold_tick[i] = r_tick;
        end else begin : g_no_repeat
            assign hold_tick[i] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debouncer
// Brief    : Randomised and directed bench for key_debouncer against a
//            window/timestamp model; also runs a REPEAT_DELAY=0 build.
// Revision : 1.0
// ============================================================================
module tb_key_debouncer;

    localparam int N  = 3;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] key_n = '1;
    logic [N-1:0] pressed,  press,  rel,  tick;
    logic [N-1:0] pressed0, press0, rel0, tick0;

    key_debouncer #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset(reset), .key_n(key_n),
        .pressed(pressed), .press(press), .release_stb(rel), .hold_tick(tick)
    );

    key_debouncer #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) dut_nr (
        .clk(clk), .reset(reset), .key_n(key_n),
        .pressed(pressed0), .press(press0), .release_stb(rel0), .hold_tick(tick0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: edge count since reset, last two key samples, last D raw levels.
    int           t;
    logic [N-1:0] khist[$];
    logic [N-1:0] rawq[$];
    logic [N-1:0] m_pressed, m_press, m_rel, m_tick;
    int           t_press[N];
    int           press_cnt[N];
    int           tick_total  = 0;
    int           tick0_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        t = 0;
        khist.delete();
        rawq.delete();
        m_pressed = '0; m_press = '0; m_rel = '0; m_tick = '0;
        for (int i = 0; i < N; i++) t_press[i] = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] k);
        logic [N-1:0] raw;
        bit           all_diff;
        int           e;
        t++;
        raw = (khist.size() >= 2) ? ~khist[0] : '0;
        khist.push_back(k);
        if (khist.size() > 2) void'(khist.pop_front());
        rawq.push_back(raw);
        if (rawq.size() > D) void'(rawq.pop_front());
        m_press = '0; m_rel = '0; m_tick = '0;
        for (int i = 0; i < N; i++) begin
            all_diff = (rawq.size() == D);
            for (int j = 0; j < rawq.size(); j++)
                if (rawq[j][i] == m_pressed[i]) all_diff = 0;
            if (all_diff) begin
                m_pressed[i] = ~m_pressed[i];
                if (m_pressed[i]) begin
                    m_press[i] = 1'b1;
                    t_press[i] = t;
                end else begin
                    m_rel[i] = 1'b1;
                end
            end else if (m_pressed[i]) begin
                e = t - t_press[i];
                if (e == RD || (e > RD && (e - RD) % RP == 0)) m_tick[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("pressed",      pressed,  m_pressed);
        chk("press",        press,    m_press);
        chk("release",      rel,      m_rel);
        chk("hold_tick",    tick,     m_tick);
        chk("pressed_nr",   pressed0, m_pressed);
        chk("press_nr",     press0,   m_press);
        chk("release_nr",   rel0,     m_rel);
        chk("hold_tick_nr", tick0,    '0);
        for (int i = 0; i < N; i++) press_cnt[i] += int'(press[i]);
        tick_total  += $countones(tick);
        tick0_total += $countones(tick0);
    endtask

    task automatic cycle(input logic [N-1:0] k);
        key_n = k;
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(k);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [N-1:0] k, input int n);
        repeat (n) cycle(k);
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_pressed"}, {pressed, pressed0}, '0);
        chk({tag, "_strobes"}, {press, rel, press0, rel0}, '0);
        chk({tag, "_tick"},    {tick, tick0}, '0);
    endtask

    logic [N-1:0] k_cur;
    int           flip_mod;

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) press_cnt[i] = 0;
        repeat (2) @(negedge clk);
        zero_check("reset");
        reset = 1'b0;
        hold(3'b111, 5);

        // Clean press / hold ticks / release on key 0
        for (int n = 1; n <= 40; n++) begin
            cycle((n < 20) ? 3'b110 : 3'b111);
            if (n == 5)  chk("clean_no_press_e5", press, 3'b000);
            if (n == 6)  chk("clean_press_e6", {pressed, press}, {3'b001, 3'b001});
            if (n == 7)  chk("clean_press_width", {pressed, press}, {3'b001, 3'b000});
            if (n == 16) chk("tick_first_e16", tick, 3'b001);
            if (n == 19) chk("tick_second_e19", tick, 3'b001);
            if (n == 22) chk("tick_third_e22", tick, 3'b001);
            if (n == 25) chk("release_e25", {rel, tick, pressed}, {3'b001, 3'b000, 3'b000});
        end

        // Bounce on key 1
        press_cnt[1] = 0;
        hold(3'b101, 3); hold(3'b111, 1); hold(3'b101, 3); hold(3'b111, 10);
        chk("bounce_no_press", press_cnt[1], 0);
        chk("bounce_pressed_low", pressed, 3'b000);
        hold(3'b101, 8);
        chk("bounce_one_press", press_cnt[1], 1);
        hold(3'b111, 10);

        // Simultaneous press on all keys
        for (int n = 1; n <= 10; n++) begin
            cycle(3'b000);
            if (n == 5) chk("simul_none_e5", press, 3'b000);
            if (n == 6) chk("simul_all_e6", press, 3'b111);
        end
        hold(3'b111, 10);

        // Reset in the middle of a hold, key kept low through reset
        hold(3'b000, 12);
        reset = 1'b1;
        #1;
        zero_check("async_reset");
        hold(3'b000, 2);
        reset = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            cycle(3'b000);
            if (n == 5)  chk("rst_press_none_e5", press, 3'b000);
            if (n == 6)  chk("rst_press_e6", press, 3'b111);
            if (n == 15) chk("rst_tick_none_e15", tick, 3'b000);
            if (n == 16) chk("rst_tick_e16", tick, 3'b111);
        end
        hold(3'b111, 10);

        // Randomised traffic with alternating bouncy / long-hold regimes and rare resets
        k_cur    = 3'b111;
        flip_mod = 3;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) flip_mod = ($urandom_range(0, 1) == 0) ? 3 : 25;
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 699) == 0) begin
                reset = 1'b1;
                #1;
                zero_check("rand_reset");
            end
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, flip_mod - 1) == 0) k_cur[i] = ~k_cur[i];
            cycle(k_cur);
        end

        chk("nr_ticks_total", tick0_total, 0);
        chk("ticks_seen", (tick_total > 0) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
